acc_drain: RTL and testbench

ACC_DRAIN -- requirements
Module: acc_drain

---
 rtl/acc_drain.sv | 182 ++++++++++++++++++
 tb/tb_acc_drain.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_drain.sv
`default_nettype none
// ============================================================================
//  Module   : acc_drain
//  Purpose  : Drains a matrix of accumulator tiles from the accumulator buffer
//             into the PPU as back-to-back bursts of AD beats. Single-pass
//             mode (i_mode == VSQ_MODE) makes one sweep of all tiles. Every
//             other mode makes two sweeps: a max/first pass, then a calc pass.
//             In the first pass a tile is read only after the array has
//             reported it written (i_tile_wr_done).
//  Ports    : i_clk, i_rst_n (async, active-low)
//             i_go / i_mode          - start one matrix drain, mode sampled on go
//             i_tile_wr_done         - one tile written by the array
//             o_acc_re / o_acc_addr  - accumulator-buffer read port
//             i_acc_rdata            - read data, one cycle after o_acc_re
//             o_ppu_start, o_acc_data, o_acc_valid, o_pass - PPU stream
//             o_busy, o_done         - drain status
//  Revision : 1.0  initial release
// ============================================================================
module acc_drain #(
    parameter int         VL       = 16,
    parameter int         ACC_W    = 24,
    parameter int         AD       = 16,
    parameter int         TILES    = 8,
    parameter int         ADDR_W   = 16,
    parameter logic [1:0] VSQ_MODE = 2'd0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_go,
    input  logic [1:0]            i_mode,
    input  logic                  i_tile_wr_done,
    output logic                  o_acc_re,
    output logic [ADDR_W-1:0]     o_acc_addr,
    input  logic [ACC_W*VL-1:0]   i_acc_rdata,
    output logic                  o_ppu_start,
    output logic [ACC_W*VL-1:0]   o_acc_data,
    output logic                  o_acc_valid,
    output logic                  o_pass,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int c_TI_W = (TILES > 1) ? $clog2(TILES) : 1;
    localparam int c_BT_W = $clog2(AD);
    localparam int c_AV_W = $clog2(TILES + 1);

    localparam logic [c_TI_W-1:0] c_LAST_TILE = c_TI_W'(TILES - 1);
    localparam logic [c_BT_W-1:0] c_LAST_BEAT = c_BT_W'(AD - 1);
    localparam logic [c_AV_W-1:0] c_AVAIL_MAX = c_AV_W'(TILES);
    localparam logic [ADDR_W-1:0] c_AD        = ADDR_W'(AD);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_BURST = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_two_pass;
    logic                r_pass;
    logic [c_TI_W-1:0]   r_tile_idx;
    // Holds the index of the next beat to issue: beat 0 goes out from WAIT,
    // so BURST always sees beats 1..AD-1 here.
    logic [c_BT_W-1:0]   r_beat;
    logic [c_AV_W-1:0]   r_avail_cnt;
    logic                r_acc_valid;

    logic                w_two_nxt;
    logic                w_pass_nxt;
    logic [c_TI_W-1:0]   w_tile_nxt;
    logic [c_BT_W-1:0]   w_beat_nxt;
    logic                w_avail_clr;
    logic                w_tile_avail;
    logic [ADDR_W-1:0]   w_base;
    logic                w_re;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_start;
    logic                w_done;

    assign w_base       = ADDR_W'(r_tile_idx) * c_AD;
    // The calc pass re-reads tiles that are already known to be complete.
    assign w_tile_avail = r_pass || (r_avail_cnt > c_AV_W'(r_tile_idx));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_two_pass  <= 1'b0;
            r_pass      <= 1'b0;
            r_tile_idx  <= '0;
            r_beat      <= '0;
            r_avail_cnt <= '0;
            r_acc_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_two_pass  <= w_two_nxt;
            r_pass      <= w_pass_nxt;
            r_tile_idx  <= w_tile_nxt;
            r_beat      <= w_beat_nxt;
            r_acc_valid <= w_re;
            if (w_avail_clr) begin
                r_avail_cnt <= '0;
            end else if (i_tile_wr_done && (r_avail_cnt != c_AVAIL_MAX)) begin
                r_avail_cnt <= r_avail_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_two_nxt   = r_two_pass;
        w_pass_nxt  = r_pass;
        w_tile_nxt  = r_tile_idx;
        w_beat_nxt  = r_beat;
        w_avail_clr = 1'b0;
        w_re        = 1'b0;
        w_addr      = '0;
        w_start     = 1'b0;
        w_done      = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (i_go) begin
                    w_two_nxt   = (i_mode != VSQ_MODE);
                    w_pass_nxt  = 1'b0;
                    w_tile_nxt  = '0;
                    w_beat_nxt  = '0;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // Holding off while the previous burst's last beat is still on
                // the PPU bus gives the AD+1 cycle minimum burst period.
                if (w_tile_avail && !r_acc_valid) begin
                    w_start     = 1'b1;
                    w_re        = 1'b1;
                    w_addr      = w_base;
                    w_beat_nxt  = c_BT_W'(1);
                    w_state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                w_re   = 1'b1;
                w_addr = w_base + ADDR_W'(r_beat);
                if (r_beat == c_LAST_BEAT) begin
                    if (r_tile_idx != c_LAST_TILE) begin
                        w_tile_nxt  = r_tile_idx + 1'b1;
                        w_state_nxt = S_WAIT;
                    end else if (r_two_pass && !r_pass) begin
                        w_pass_nxt  = 1'b1;
                        w_tile_nxt  = '0;
                        w_state_nxt = S_WAIT;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_beat_nxt = r_beat + 1'b1;
                end
            end
            S_DONE: begin
                if (!r_acc_valid) begin
                    w_done      = 1'b1;
                    w_avail_clr = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_acc_re    = w_re;
    assign o_acc_addr  = w_addr;
    assign o_ppu_start = w_start;
    assign o_acc_valid = r_acc_valid;
    assign o_acc_data  = r_acc_valid ? i_acc_rdata : '0;
    assign o_pass      = r_pass;
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = w_done;

endmodule
`default_nettype wire

// File: tb/tb_acc_drain.sv
`default_nettype none
// ============================================================================
//  Module   : tb_acc_drain
//  Purpose  : Self-checking bench for acc_drain (AD=4, TILES=2). Burst start
//             times come from a cycle-level model of the drain rules; beat
//             addresses and data are derived from those start times and a
//             randomly filled accumulator-buffer model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_acc_drain;

    localparam int         VL     = 2;
    localparam int         ACC_W  = 8;
    localparam int         AD     = 4;
    localparam int         TILES  = 2;
    localparam int         ADDR_W = 16;
    localparam logic [1:0] VSQ    = 2'd0;
    localparam int         DW     = VL * ACC_W;
    localparam int         DEPTH  = AD * TILES;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              go = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic              wr_done = 1'b0;
    logic              acc_re;
    logic [ADDR_W-1:0] acc_addr;
    logic [DW-1:0]     rdata = '0;
    logic              ppu_start;
    logic [DW-1:0]     acc_data;
    logic              acc_valid;
    logic              pass;
    logic              busy;
    logic              done;

    acc_drain #(
        .VL(VL), .ACC_W(ACC_W), .AD(AD), .TILES(TILES), .ADDR_W(ADDR_W), .VSQ_MODE(VSQ)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_go(go), .i_mode(mode),
        .i_tile_wr_done(wr_done), .o_acc_re(acc_re), .o_acc_addr(acc_addr),
        .i_acc_rdata(rdata), .o_ppu_start(ppu_start), .o_acc_data(acc_data),
        .o_acc_valid(acc_valid), .o_pass(pass), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Accumulator buffer: one-cycle read latency, garbage when not read.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (acc_re && int'(acc_addr) < DEPTH) rdata <= mem[int'(acc_addr)];
        else                                  rdata <= DW'($urandom);
    end

    // Observation logs (absolute cycle numbers), sampled on the falling edge.
    bit            log_en = 1'b0;
    int            st_q[$];
    int            st_pass[$];
    int            re_c[$];
    int            re_a[$];
    int            v_c[$];
    logic [DW-1:0] v_d[$];
    int            dn_q[$];
    int            busy_n;
    int            junk_n;

    always @(negedge clk) begin
        if (log_en) begin
            if (ppu_start) begin st_q.push_back(cyc); st_pass.push_back(int'(pass)); end
            if (acc_re) begin re_c.push_back(cyc); re_a.push_back(int'(acc_addr)); end
            if (acc_valid) begin v_c.push_back(cyc); v_d.push_back(acc_data); end
            else if (acc_data != '0) junk_n++;
            if (done) dn_q.push_back(cyc);
            if (busy) busy_n++;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: start times relative to the i_go cycle.
    int go_cyc;
    int avail_rel[TILES];
    int e_st[$];
    int e_done;

    task automatic clear_logs();
        st_q.delete(); st_pass.delete(); re_c.delete(); re_a.delete();
        v_c.delete(); v_d.delete(); dn_q.delete(); busy_n = 0; junk_n = 0;
    endtask

    // Each burst starts at the earliest cycle that is both AD+1 after the
    // previous burst start and, in the first pass, no earlier than the
    // cycle its tile became available. Done follows the last beat.
    task automatic build_expect(input int passes);
        int nxt;
        int s;
        nxt = 1;
        e_st.delete();
        for (int p = 0; p < passes; p++) begin
            for (int t = 0; t < TILES; t++) begin
                s = nxt;
                if (p == 0 && avail_rel[t] > s) s = avail_rel[t];
                e_st.push_back(s);
                nxt = s + AD + 1;
            end
        end
        e_done = nxt;
    endtask

    function automatic int start_errs();
        int n;
        n = 0;
        if (st_q.size() != e_st.size()) return 1;
        foreach (e_st[b]) begin
            if (st_q[b] != go_cyc + e_st[b] || st_pass[b] != b / TILES) n++;
        end
        return n;
    endfunction

    function automatic int beat_errs();
        int n;
        int i;
        int a;
        int t;
        n = 0;
        if (re_c.size() != e_st.size() * AD) n++;
        if (v_c.size() != e_st.size() * AD) n++;
        if (n != 0) return n;
        foreach (e_st[b]) begin
            for (int k = 0; k < AD; k++) begin
                i = b * AD + k;
                a = (b % TILES) * AD + k;
                t = go_cyc + e_st[b] + k;
                if (re_c[i] != t || re_a[i] != a) n++;
                if (v_c[i] != t + 1 || v_d[i] !== mem[a]) n++;
            end
        end
        return n;
    endfunction

    task automatic prewrite(input int n);
        for (int i = 0; i < n; i++) begin
            wr_done = 1'b1; @(negedge clk);
            wr_done = 1'b0; @(negedge clk);
        end
    endtask

    // n_avail tiles are already written; the rest are written during the
    // drain at go+late_at, go+late_at+gap, ... A second i_go is pulsed at
    // go+go2_rel when go2_rel > 0.
    task automatic run_drain(input logic [1:0] m, input int n_avail,
                             input int late_at, input int gap, input int go2_rel);
        for (int t = 0; t < TILES; t++)
            avail_rel[t] = (t < n_avail) ? 0 : late_at + (t - n_avail) * gap + 1;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        build_expect((m == VSQ) ? 1 : 2);
        clear_logs();
        log_en = 1'b1;
        go_cyc = cyc;
        for (int r = 0; r < e_done + 4; r++) begin
            go      = (r == 0) || (go2_rel > 0 && r == go2_rel);
            mode    = (r == 0) ? m : 2'($urandom);
            wr_done = 1'b0;
            for (int t = n_avail; t < TILES; t++)
                if (r == late_at + (t - n_avail) * gap) wr_done = 1'b1;
            @(negedge clk);
        end
        go = 1'b0; wr_done = 1'b0; log_en = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_chk++;
        if ({ppu_start, acc_re, acc_addr, acc_data, acc_valid, pass, busy, done} !== '0)
            $display("FAIL reset_outputs: got re=%b addr=%0d valid=%b busy=%b done=%b, want all 0",
                     acc_re, acc_addr, acc_valid, busy, done);
        else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({ppu_start, acc_re, acc_valid, busy, done} !== 5'b0)
            $display("FAIL idle_after_reset: got start=%b re=%b valid=%b busy=%b done=%b, want 0",
                     ppu_start, acc_re, acc_valid, busy, done);
        else n_pass++;
    endtask

    task automatic test_single_pass();
        prewrite(TILES);
        run_drain(VSQ, TILES, 0, 1, 0);
        n_chk++;
        if (st_q.size() != 2 || st_q[0] - go_cyc != 1 || st_q[1] - go_cyc != 6)
            $display("FAIL single_starts: got %0d bursts first at %0d, want starts at 1 and 6",
                     st_q.size(), (st_q.size() > 0) ? st_q[0] - go_cyc : -1);
        else n_pass++;
        n_chk++;
        if (beat_errs() != 0) $display("FAIL single_beats: got %0d bad beats, want 0", beat_errs());
        else n_pass++;
        n_chk++;
        if (dn_q.size() != 1 || dn_q[0] - go_cyc != 11)
            $display("FAIL single_done: got %0d pulses first at %0d, want 1 at 11",
                     dn_q.size(), (dn_q.size() > 0) ? dn_q[0] - go_cyc : -1);
        else n_pass++;
        n_chk++;
        if (busy_n != 11 || junk_n != 0)
            $display("FAIL single_busy: got busy=%0d junk=%0d, want busy=11 junk=0", busy_n, junk_n);
        else n_pass++;
    endtask

    task automatic test_two_pass();
        prewrite(TILES);
        run_drain(2'($urandom_range(1, 3)), TILES, 0, 1, 0);
        n_chk++;
        if (start_errs() != 0)
            $display("FAIL two_pass_starts: got %0d bursts with %0d bad, want %0d",
                     st_q.size(), start_errs(), e_st.size());
        else n_pass++;
        n_chk++;
        if (beat_errs() != 0) $display("FAIL two_pass_beats: got %0d bad beats, want 0", beat_errs());
        else n_pass++;
        n_chk++;
        if (dn_q.size() != 1 || dn_q[0] != go_cyc + e_done)
            $display("FAIL two_pass_done: got %0d pulses, want 1 at %0d", dn_q.size(), e_done);
        else n_pass++;
    endtask

    task automatic test_starve();
        int late;
        late = int'($urandom_range(6, 20));
        prewrite(1);
        run_drain(2'd1, 1, late, 1, 0);
        n_chk++;
        if (st_q.size() < 2 || st_q[1] - go_cyc != late + 1)
            $display("FAIL starve_second_start: got %0d, want %0d",
                     (st_q.size() > 1) ? st_q[1] - go_cyc : -1, late + 1);
        else n_pass++;
        n_chk++;
        if (start_errs() != 0 || beat_errs() != 0)
            $display("FAIL starve_sequence: got %0d bad starts %0d bad beats, want 0",
                     start_errs(), beat_errs());
        else n_pass++;
        n_chk++;
        if (dn_q.size() != 1 || dn_q[0] != go_cyc + e_done)
            $display("FAIL starve_done: got %0d pulses, want 1 at %0d", dn_q.size(), e_done);
        else n_pass++;
    endtask

    task automatic test_go_ignore();
        prewrite(TILES);
        run_drain(VSQ, TILES, 0, 1, 3);
        n_chk++;
        if (start_errs() != 0 || beat_errs() != 0)
            $display("FAIL go_ignore_sequence: got %0d bad starts %0d bad beats, want 0",
                     start_errs(), beat_errs());
        else n_pass++;
        n_chk++;
        if (dn_q.size() != 1)
            $display("FAIL go_ignore_done_count: got %0d, want 1", dn_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        prewrite(TILES);
        clear_logs();
        mode = VSQ; go = 1'b1; go_cyc = cyc; log_en = 1'b1;
        @(negedge clk); go = 1'b0;
        @(negedge clk); @(negedge clk);
        n_chk++;
        if (!acc_re || acc_addr !== 16'd2)
            $display("FAIL reset_mid_beat2: got re=%b addr=%0d, want re=1 addr=2", acc_re, acc_addr);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({ppu_start, acc_re, acc_addr, acc_data, acc_valid, pass, busy, done} !== '0)
            $display("FAIL reset_mid_outputs: got re=%b addr=%0d valid=%b busy=%b, want all 0",
                     acc_re, acc_addr, acc_valid, busy);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        repeat (10) @(negedge clk);
        log_en = 1'b0;
        n_chk++;
        if (v_c.size() != 0 || st_q.size() != 0)
            $display("FAIL reset_mid_quiet: got %0d valid beats %0d starts, want 0", v_c.size(), st_q.size());
        else n_pass++;
        prewrite(TILES);
        run_drain(VSQ, TILES, 0, 1, 0);
        n_chk++;
        if (re_a.size() == 0 || re_a[0] != 0 || beat_errs() != 0)
            $display("FAIL reset_mid_restart: got first addr %0d with %0d bad beats, want addr 0 and 0",
                     (re_a.size() > 0) ? re_a[0] : -1, beat_errs());
        else n_pass++;
    endtask

    task automatic test_saturation();
        prewrite(TILES + 3);
        n_chk++;
        if (int'(dut.r_avail_cnt) != TILES)
            $display("FAIL saturation_count: got %0d, want %0d", int'(dut.r_avail_cnt), TILES);
        else n_pass++;
        run_drain(2'd3, TILES, 0, 1, 0);
        n_chk++;
        if (st_q.size() != 2 * TILES || start_errs() != 0 || beat_errs() != 0)
            $display("FAIL saturation_bursts: got %0d bursts (%0d bad beats), want %0d",
                     st_q.size(), beat_errs(), 2 * TILES);
        else n_pass++;
        n_chk++;
        if (int'(dut.r_avail_cnt) != 0)
            $display("FAIL saturation_clear: got %0d, want 0", int'(dut.r_avail_cnt));
        else n_pass++;
    endtask

    task automatic test_random();
        logic [1:0] m;
        int         n_av;
        for (int it = 0; it < 8; it++) begin
            m    = 2'($urandom);
            n_av = int'($urandom_range(0, TILES));
            prewrite(n_av);
            run_drain(m, n_av, int'($urandom_range(2, 15)), int'($urandom_range(1, 8)), 0);
            n_chk++;
            if (start_errs() != 0 || beat_errs() != 0)
                $display("FAIL random_%0d_sequence: got %0d bad starts %0d bad beats (mode %0d avail %0d), want 0",
                         it, start_errs(), beat_errs(), m, n_av);
            else n_pass++;
            n_chk++;
            if (dn_q.size() != 1 || dn_q[0] != go_cyc + e_done || busy_n != e_done || junk_n != 0)
                $display("FAIL random_%0d_done: got %0d pulses busy=%0d junk=%0d, want 1 at %0d busy=%0d",
                         it, dn_q.size(), busy_n, junk_n, e_done, e_done);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_two_pass();
        test_starve();
        test_go_ignore();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
